// File: rtl/gpio_bank_cfg.sv
// Multi-channel configurable GPIO bank: ccff scan chain into a shadow register,
// count-checked commit to the active config, per-channel direction/output-reg/input-sync.
module gpio_bank_cfg #(
  parameter int unsigned NUM_IO      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              config_en,
  input  logic              ccff_head,
  output logic              ccff_tail,
  input  logic              config_commit,
  output logic              config_valid,
  output logic              chain_full,
  output logic              cfg_err,
  input  logic [NUM_IO-1:0] gpio_a,
  output logic [NUM_IO-1:0] gpio_y,
  input  logic [NUM_IO-1:0] pad_in,
  output logic [NUM_IO-1:0] pad_out,
  output logic [NUM_IO-1:0] pad_oe
);

  localparam int unsigned CFG_W = 3;
  localparam int unsigned L     = NUM_IO * CFG_W;
  localparam int unsigned CNT_W = $clog2(L + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(L);

  logic [L-1:0]      sr_q, sr_d;
  logic [L-1:0]      act_q, act_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [NUM_IO-1:0] a_q, a_d;
  logic [NUM_IO-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IO-1:0] sync_d [SYNC_STAGES];

  // Shift has priority over commit; a commit in a shift cycle is dropped silently.
  always_comb begin
    sr_d    = sr_q;
    act_d   = act_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (config_en) begin
      sr_d = {sr_q[L-2:0], ccff_head};
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
    end else if (config_commit) begin
      if (cnt_q == CNT_FULL) begin
        act_d   = sr_q;
        valid_d = 1'b1;
        err_d   = 1'b0;
        cnt_d   = '0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    a_d       = gpio_a;
    sync_d[0] = pad_in;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      sr_q    <= '0;
      act_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      a_q     <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sr_q    <= sr_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      a_q     <= a_d;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end

  // Field per channel k: [3k] DIR, [3k+1] OREG, [3k+2] IREG.
  always_comb begin
    pad_oe  = '0;
    pad_out = '0;
    gpio_y  = '0;
    for (int unsigned k = 0; k < NUM_IO; k++) begin
      if (valid_q) begin
        pad_oe[k]  = act_q[CFG_W*k];
        pad_out[k] = act_q[CFG_W*k+1] ? a_q[k] : gpio_a[k];
        if (!act_q[CFG_W*k])
          gpio_y[k] = act_q[CFG_W*k+2] ? sync_q[SYNC_STAGES-1][k] : pad_in[k];
      end
    end
  end

  assign ccff_tail    = sr_q[L-1];
  assign chain_full   = (cnt_q == CNT_FULL);
  assign config_valid = valid_q;
  assign cfg_err      = err_q;

endmodule

// File: tb/tb_gpio_bank_cfg.sv
// Directed bench for gpio_bank_cfg (NUM_IO=2) with a queue-based behavioural model
// checked every cycle, plus hand-computed literal expectations.
module tb_gpio_bank_cfg;

  localparam int unsigned NUM_IO = 2;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned L      = NUM_IO * 3;

  logic              clk = 1'b0;
  logic              rst, cen, head, commit;
  logic              tail, valid, full, err;
  logic [NUM_IO-1:0] a, y, pin, pout, poe;

  int n_checks = 0;
  int n_errors = 0;

  gpio_bank_cfg #(.NUM_IO(NUM_IO), .SYNC_STAGES(SYNC)) dut (
    .prog_clk(clk), .pReset(rst), .config_en(cen), .ccff_head(head),
    .ccff_tail(tail), .config_commit(commit), .config_valid(valid),
    .chain_full(full), .cfg_err(err), .gpio_a(a), .gpio_y(y),
    .pad_in(pin), .pad_out(pout), .pad_oe(poe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: chain holds the last L bits shifted in, oldest first (front is the tail bit).
  bit                chain[$];
  bit [NUM_IO-1:0]   pin_hist[$];
  int                m_cnt;
  bit                m_valid, m_err;
  bit [NUM_IO-1:0]   m_dir, m_oreg, m_ireg, m_aprev;

  task automatic model_reset();
    chain.delete();
    repeat (L) chain.push_back(1'b0);
    pin_hist.delete();
    repeat (SYNC) pin_hist.push_back('0);
    m_cnt = 0; m_valid = 0; m_err = 0;
    m_dir = '0; m_oreg = '0; m_ireg = '0; m_aprev = '0;
  endtask

  initial model_reset();

  always @(posedge clk) begin
    if (rst) model_reset();
    else begin
      if (cen) begin
        chain.push_back(head);
        void'(chain.pop_front());
        if (m_cnt < L) m_cnt++;
      end else if (commit) begin
        if (m_cnt == L) begin
          // bit j of channel k is the one shifted in (3k+j) shifts before the newest
          for (int k = 0; k < NUM_IO; k++) begin
            m_dir[k]  = chain[L-1-3*k];
            m_oreg[k] = chain[L-2-3*k];
            m_ireg[k] = chain[L-3-3*k];
          end
          m_valid = 1; m_err = 0; m_cnt = 0;
        end else m_err = 1;
      end
      m_aprev = a;
      pin_hist.push_back(pin);
      void'(pin_hist.pop_front());
    end
  end

  always @(negedge clk) begin
    logic [NUM_IO-1:0] e_oe, e_out, e_y;
    #3;
    e_oe = '0; e_out = '0; e_y = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      if (m_valid) begin
        e_oe[k]  = m_dir[k];
        e_out[k] = m_oreg[k] ? m_aprev[k] : a[k];
        if (!m_dir[k]) e_y[k] = m_ireg[k] ? pin_hist[0][k] : pin[k];
      end
    end
    check("m_tail", tail, chain[0]);
    check("m_full", full, m_cnt == L);
    check("m_valid", valid, m_valid);
    check("m_err", err, m_err);
    check("m_pad_oe", poe, e_oe);
    check("m_pad_out", pout, e_out);
    check("m_gpio_y", y, e_y);
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic shift(input bit b);
    cen = 1; head = b;
    cyc();
    cen = 0; head = 0;
  endtask

  task automatic pulse_commit();
    commit = 1;
    cyc();
    commit = 0;
  endtask

  initial begin
    bit b9 [9];
    b9 = '{1, 1, 0, 1, 0, 1, 0, 1, 1};
    rst = 1; cen = 0; head = 0; commit = 0; a = '0; pin = '0;
    cyc(); cyc();
    check("rst_outs", {tail, full, err, valid, poe, pout, y}, '0);
    rst = 0;

    // 1: commits with empty chain are rejected
    repeat (3) pulse_commit();
    check("t1_err", err, 1'b1);
    check("t1_valid", valid, 1'b0);

    // 2: ch1 = IREG only, ch0 = DIR only
    shift(1); shift(0); shift(0); shift(0); shift(0);
    check("t2_full5", full, 1'b0);
    shift(1);
    check("t2_full6", full, 1'b1);
    pulse_commit();
    check("t2_valid", valid, 1'b1);
    check("t2_err", err, 1'b0);
    check("t2_full_clr", full, 1'b0);
    check("t2_oe", poe, 2'b01);
    a = 2'b01;
    #1;
    check("t2_out_comb", pout, 2'b01);

    // 3: synchronised input on ch1
    pin = 2'b10;
    cyc();
    check("t3_y_1edge", y, 2'b00);
    cyc();
    check("t3_y_2edge", y, 2'b10);
    pin = 2'b11;
    cyc();
    check("t3_y0_zero", y, 2'b10);

    // 4: short chain rejected, then completed: ch1 plain input, ch0 registered output
    a = 2'b00; pin = 2'b00;
    shift(0); shift(0); shift(0); shift(0); shift(1);
    pulse_commit();
    check("t4_rej_err", err, 1'b1);
    check("t4_rej_oe", poe, 2'b01);
    check("t4_rej_valid", valid, 1'b1);
    shift(1);
    pulse_commit();
    check("t4_acc_err", err, 1'b0);
    check("t4_acc_oe", poe, 2'b01);
    a = 2'b01;
    #1;
    check("t4_oreg_hold", pout, 2'b00);
    cyc();
    check("t4_oreg_late", pout, 2'b01);
    pin = 2'b10;
    #1;
    check("t4_y_comb", y, 2'b10);

    // 5: commit coincident with the 6th shift is ignored
    shift(0); shift(0); shift(1); shift(1); shift(0);
    cen = 1; head = 0; commit = 1;
    cyc();
    cen = 0; commit = 0;
    check("t5_full", full, 1'b1);
    check("t5_err", err, 1'b0);
    check("t5_oe_old", poe, 2'b01);
    pulse_commit();
    check("t5_oe_new", poe, 2'b10);
    check("t5_full_clr", full, 1'b0);

    // 6: overshift; tail emits the first bits, counter saturates
    for (int i = 0; i < 9; i++) begin
      shift(b9[i]);
      if (i >= 5 && i <= 7) check("t6_tail", tail, b9[i-5]);
    end
    check("t6_full", full, 1'b1);
    pulse_commit();
    check("t6_err", err, 1'b0);
    check("t6_oe", poe, 2'b11);

    // reset mid-shift loses progress
    shift(1); shift(0); shift(1);
    rst = 1;
    cyc();
    rst = 0;
    check("rst_mid_valid", valid, 1'b0);
    pulse_commit();
    check("rst_mid_err", err, 1'b1);
    check("rst_mid_oe", poe, 2'b00);

    cyc(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gpio_bank_cfg.md
Name: gpio_bank_cfg

Overview:
- Parametrised multi-channel successor to the single-pad configurable I/O tile.
- Holds NUM_IO GPIO channels. Each channel has 3 configuration bits: direction, output register and input synchroniser.
- Configuration is loaded through a ccff scan chain into a shadow register. It takes effect only when a commit is accepted, and the commit is checked against the shift count.
- Sits in the I/O tile between fabric logic and pad cells. It exposes split pad signals (in/out/oe) so the netlist stays synthesizable.

Parameters:
- NUM_IO, 8, number of GPIO channels (1..64).
- SYNC_STAGES, 2, input synchroniser depth when IREG=1 (1..3).
- Derived, fixed: CFG_W = 3 bits per channel; L = NUM_IO*3 chain length; CNT_W = clog2(L+1).

Ports:
- prog_clk  in  1  sole clock, rising edge.
- pReset  in  1  synchronous active-high reset.
- config_en  in  1  shift the chain this cycle.
- ccff_head  in  1  serial config in.
- ccff_tail  out  1  serial config out = MSB of the shadow chain.
- config_commit  in  1  request copy of shadow chain to the active config (single-cycle pulse).
- config_valid  out  1  active config loaded.
- chain_full  out  1  exactly L shifts seen since the last reset or accepted commit.
- cfg_err  out  1  sticky: commit rejected.
- gpio_a  in  NUM_IO  fabric data to pads.
- gpio_y  out  NUM_IO  pad data to fabric.
- pad_in  in  NUM_IO  from pad cell.
- pad_out  out  NUM_IO  to pad cell.
- pad_oe  out  NUM_IO  pad driver enable, 1 = drive.

Behaviour:
- Reset (pReset=1 at a clock edge) clears all state:
  - shadow chain sr, active config act, shift counter, config_valid, cfg_err, output registers and synchronisers all go to 0.
  - Outputs: ccff_tail=0, chain_full=0, cfg_err=0, config_valid=0, pad_oe=0, pad_out=0, gpio_y=0.
  - Reset overrides every other input in the same cycle.
- Chain shift (config_en=1):
  - sr <= {sr[L-2:0], ccff_head}; ccff_tail = sr[L-1] (registered, so 1-cycle-per-bit latency).
  - Counter increments and saturates at L. Shifts beyond L still shift data; the counter stays at L.
- Channel k field is sr[3k+2:3k]:
  - bit0 DIR (1 = output).
  - bit1 OREG.
  - bit2 IREG.
  - The first bit shifted in after L shifts lands in channel NUM_IO-1 bit2.
- Commit, evaluated only when config_commit=1 and config_en=0:
  - counter==L (accept): act <= sr, config_valid <= 1, cfg_err <= 0, counter <= 0.
  - counter!=L (reject): act and config_valid unchanged, cfg_err <= 1, counter unchanged.
  - config_commit with config_en=1 in the same cycle: commit ignored (not an error), shift performed.
- chain_full = (counter==L), combinational from the counter.
- Shifting does not disturb act; the pads keep running the old config until an accepted commit.
- Output path, per channel k:
  - pad_oe[k] = config_valid & DIR.
  - OREG=0: pad_out[k] = gpio_a[k] (combinational).
  - OREG=1: pad_out[k] = a_q[k], where a_q <= gpio_a every cycle (1-cycle latency).
  - pad_out is forced to 0 when config_valid=0.
- Input path, per channel k:
  - config_valid & ~DIR, IREG=0: gpio_y[k] = pad_in[k] (combinational).
  - config_valid & ~DIR, IREG=1: gpio_y[k] = last stage of a SYNC_STAGES flop chain fed by pad_in[k] (latency SYNC_STAGES cycles).
  - Otherwise: gpio_y[k] = 0.
  - The synchroniser shifts every cycle regardless of config, so a switch to IREG=1 produces valid data immediately if pad_in was stable.
- Config change at commit: new act applies from the cycle after the accepted commit edge; no glitch state is defined beyond that cycle.
- Reset mid-shift or mid-commit: all progress is lost and the counter returns to 0. A subsequent commit without L fresh shifts sets cfg_err.

Test Plan:
1. Reset with NUM_IO=2, L=6 -> all outputs 0. Then 3 commits -> cfg_err=1, config_valid=0.
2. Shift 6 bits 1,0,0,0,0,1 (ch1 = IREG only; ch0 = DIR only) -> chain_full=1 after the 6th edge. Commit -> config_valid=1, cfg_err=0, counter=0. pad_oe=2'b01; gpio_a[0]=1 -> pad_out[0]=1 same cycle.
3. Same config, pad_in[1] 0->1 with SYNC_STAGES=2 -> gpio_y[1] rises exactly 2 edges later; gpio_y[0]=0 throughout.
4. Shift 5 bits then commit -> rejected: cfg_err=1, old config still active. Shift 1 more, commit -> accepted, cfg_err=0.
5. config_en=1 and config_commit=1 in the same cycle at counter==5 -> shift taken, counter=6, no commit, no error. Next-cycle commit accepted.
6. Shift L+3 bits, ccff_tail monitored -> tail emits the first 3 bits shifted in, delayed by L cycles. Counter saturates at 6, and a commit is accepted with sr holding the last 6 bits.
